// File: rtl/md4_pkg.sv
// Shared MD4 definitions: digest geometry, checker FSM encoding and the
// chaining-variable initial values also used by the hasher.
package md4_pkg;

    localparam int DIGEST_BYTES = 16;
    localparam int CNT_W        = 5;

    localparam logic [31:0] MD4_INIT_A = 32'h67452301;
    localparam logic [31:0] MD4_INIT_B = 32'hefcdab89;
    localparam logic [31:0] MD4_INIT_C = 32'h98badcfe;
    localparam logic [31:0] MD4_INIT_D = 32'h10325476;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_COMPARE = 2'd2,
        ST_REPORT  = 2'd3
    } state_t;

endpackage

// File: rtl/md4_digest_shift.sv
// Byte-serial digest assembly register: byte at position cnt lands in the
// most-significant free slot, so byte 0 ends up in the top byte.
module md4_digest_shift #(
    parameter int BYTES = 16,
    parameter int CNT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               load,
    input  logic [7:0]         byte_in,
    output logic [CNT_W-1:0]   cnt,
    output logic [BYTES*8-1:0] data
);

    logic [CNT_W-1:0]   cnt_r;
    logic [BYTES*8-1:0] data_r;

    // Byte counter and assembly storage; clear only rewinds the counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r  <= {CNT_W{1'b0}};
            data_r <= {(BYTES*8){1'b0}};
        end else if (clear) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (load) begin
            data_r[(BYTES - 1 - int'(cnt_r)) * 8 +: 8] <= byte_in;
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign cnt  = cnt_r;
    assign data = data_r;

endmodule

// File: rtl/md4_digest_checker.sv
// Collects a byte-serial MD4 digest from the hasher, compares it with the
// target digest and keeps a sticky record of the first matching candidate.
module md4_digest_checker #(
    parameter int DIGEST_BYTES = md4_pkg::DIGEST_BYTES,
    parameter int ID_W         = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [127:0]    target_digest,
    input  logic [ID_W-1:0] candidate_id,
    input  logic            digest_valid,
    input  logic [7:0]      digest_byte,
    input  logic            digest_last,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic            match,
    output logic            error,
    output logic            found,
    output logic [ID_W-1:0] found_id,
    output logic [127:0]    digest_out
);
    import md4_pkg::*;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGEST_BYTES - 1);

    state_t          state_r;
    state_t          state_s;
    logic            accept_s;
    logic            start_acc_s;
    logic            frame_err_s;
    logic [CNT_W-1:0] cnt_s;
    logic [127:0]    asm_s;

    logic [127:0]    target_r;
    logic [ID_W-1:0] cand_r;
    logic            err_r;
    logic            cmp_r;
    logic            ready_r;
    logic            busy_r;
    logic            done_r;
    logic            match_r;
    logic            error_r;
    logic            found_r;
    logic [ID_W-1:0] found_id_r;
    logic [127:0]    digest_out_r;

    md4_digest_shift #(
        .BYTES (DIGEST_BYTES),
        .CNT_W (CNT_W)
    ) u_shift (
        .clk     (clk),
        .reset   (reset),
        .clear   (start_acc_s),
        .load    (accept_s),
        .byte_in (digest_byte),
        .cnt     (cnt_s),
        .data    (asm_s)
    );

    // Next-state decode; a framing error skips COMPARE and reports directly.
    always_comb begin
        state_s     = state_r;
        start_acc_s = 1'b0;
        frame_err_s = 1'b0;
        accept_s    = digest_valid && ready_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s     = ST_COLLECT;
                    start_acc_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (accept_s) begin
                    if ((cnt_s == LAST_CNT) && digest_last) begin
                        state_s = ST_COMPARE;
                    end else if (digest_last || (cnt_s == LAST_CNT)) begin
                        state_s     = ST_REPORT;
                        frame_err_s = 1'b1;
                    end else begin
                        state_s = ST_COLLECT;
                    end
                end else begin
                    state_s = ST_COLLECT;
                end
            end
            ST_COMPARE: state_s = ST_REPORT;
            ST_REPORT:  state_s = ST_IDLE;
            default:    state_s = ST_IDLE;
        endcase
    end

    // State register plus status flags registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            ready_r <= (state_s == ST_COLLECT);
            busy_r  <= (state_s != ST_IDLE);
            done_r  <= (state_r == ST_REPORT);
        end
    end

    // Per-digest context: target, candidate, framing flag and compare result.
    always_ff @(posedge clk) begin
        if (reset) begin
            target_r <= 128'd0;
            cand_r   <= {ID_W{1'b0}};
            err_r    <= 1'b0;
            cmp_r    <= 1'b0;
        end else if (start_acc_s) begin
            target_r <= target_digest;
            cand_r   <= candidate_id;
            err_r    <= 1'b0;
            cmp_r    <= 1'b0;
        end else if (frame_err_s) begin
            err_r <= 1'b1;
        end else if (state_r == ST_COMPARE) begin
            cmp_r <= (asm_s == target_r);
        end
    end

    // Result outputs update only when a digest is reported; found is sticky.
    always_ff @(posedge clk) begin
        if (reset) begin
            match_r      <= 1'b0;
            error_r      <= 1'b0;
            found_r      <= 1'b0;
            found_id_r   <= {ID_W{1'b0}};
            digest_out_r <= 128'd0;
        end else if (state_r == ST_REPORT) begin
            match_r      <= cmp_r && !err_r;
            error_r      <= err_r;
            digest_out_r <= asm_s;
            if (cmp_r && !err_r) begin
                found_r <= 1'b1;
                if (!found_r) begin
                    found_id_r <= cand_r;
                end
            end
        end
    end

    assign ready      = ready_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign match      = match_r;
    assign error      = error_r;
    assign found      = found_r;
    assign found_id   = found_id_r;
    assign digest_out = digest_out_r;

endmodule

// File: tb/tb_md4_digest_checker.sv
// Directed bench for md4_digest_checker: MD4("") stream, mismatch, framing
// error, first-match retention, random gaps and mid-digest reset.
module tb_md4_digest_checker;

    localparam logic [127:0] MD4_EMPTY = 128'h31d6cfe0d16ae931b73c59d7e0c089c0;
    localparam logic [127:0] MD4_C1    = 128'h31d6cfe0d16ae931b73c59d7e0c089c1;
    localparam logic [127:0] GAP_DIG   = 128'h0123456789abcdeffedcba9876543210;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] target_digest;
    logic [31:0]  candidate_id;
    logic         digest_valid;
    logic [7:0]   digest_byte;
    logic         digest_last;
    logic         ready;
    logic         busy;
    logic         done;
    logic         match;
    logic         error;
    logic         found;
    logic [31:0]  found_id;
    logic [127:0] digest_out;

    int total = 0;
    int bad   = 0;

    md4_digest_checker #(
        .DIGEST_BYTES (16),
        .ID_W         (32)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .target_digest (target_digest),
        .candidate_id  (candidate_id),
        .digest_valid  (digest_valid),
        .digest_byte   (digest_byte),
        .digest_last   (digest_last),
        .ready         (ready),
        .busy          (busy),
        .done          (done),
        .match         (match),
        .error         (error),
        .found         (found),
        .found_id      (found_id),
        .digest_out    (digest_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, ready, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_match"}, match, 1'b0);
        check({tag, "_error"}, error, 1'b0);
        check({tag, "_found"}, found, 1'b0);
        check({tag, "_found_id"}, found_id, 32'd0);
        check({tag, "_digest_out"}, digest_out, 128'd0);
    endtask

    task automatic do_start(input string tag, input logic [31:0] id, input logic [127:0] tgt);
        start         = 1'b1;
        candidate_id  = id;
        target_digest = tgt;
        tick();
        start = 1'b0;
        check({tag, "_busy_on_start"}, busy, 1'b1);
        check({tag, "_ready_on_start"}, ready, 1'b1);
    endtask

    task automatic send_digest(input logic [127:0] d, input int err_pos, input int gap_pct);
        int g;
        for (int i = 0; i < 16; i++) begin
            g = 0;
            while (gap_pct > 0 && g < 6 && $urandom_range(0, 99) < gap_pct) begin
                digest_valid = 1'b0;
                tick();
                g++;
            end
            digest_valid = 1'b1;
            digest_byte  = d[127 - 8*i -: 8];
            digest_last  = (i == 15) || (i == err_pos);
            tick();
            if (i == err_pos) break;
        end
        digest_valid = 1'b0;
        digest_last  = 1'b0;
    endtask

    task automatic expect_done(input string tag, input int lat, input logic exp_match,
                               input logic exp_err, input logic [127:0] exp_dig,
                               input logic chk_dig, input logic rep_start);
        check({tag, "_done_e0"}, done, 1'b0);
        for (int i = 1; i < lat; i++) begin
            tick();
            check({tag, "_done_early"}, done, 1'b0);
            if (i == lat - 1 && rep_start) begin
                start         = 1'b1;
                candidate_id  = 32'hdead;
                target_digest = ~128'd0;
            end
        end
        tick();
        start = 1'b0;
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_match"}, match, exp_match);
        check({tag, "_error"}, error, exp_err);
        check({tag, "_busy_at_done"}, busy, 1'b0);
        if (chk_dig) check({tag, "_digest_out"}, digest_out, exp_dig);
        tick();
        check({tag, "_done_pulse"}, done, 1'b0);
        check({tag, "_match_hold"}, match, exp_match);
        check({tag, "_error_hold"}, error, exp_err);
        check({tag, "_busy_after"}, busy, 1'b0);
    endtask

    initial begin
        reset         = 1'b1;
        start         = 1'b0;
        target_digest = 128'd0;
        candidate_id  = 32'd0;
        digest_valid  = 1'b0;
        digest_byte   = 8'd0;
        digest_last   = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // MD4("") with equal target; a start during REPORT must be ignored.
        do_start("empty", 32'd5, MD4_EMPTY);
        send_digest(MD4_EMPTY, -1, 0);
        expect_done("empty", 2, 1'b1, 1'b0, MD4_EMPTY, 1'b1, 1'b1);
        check("empty_found", found, 1'b1);
        check("empty_found_id", found_id, 32'd5);

        // Target differs only in the last byte.
        do_start("c1", 32'd6, MD4_C1);
        send_digest(MD4_EMPTY, -1, 0);
        expect_done("c1", 2, 1'b0, 1'b0, MD4_EMPTY, 1'b1, 1'b0);
        check("c1_found", found, 1'b1);
        check("c1_found_id", found_id, 32'd5);

        // Early digest_last on byte 9.
        do_start("err9", 32'd7, MD4_EMPTY);
        send_digest(MD4_EMPTY, 9, 0);
        expect_done("err9", 1, 1'b0, 1'b1, 128'd0, 1'b0, 1'b0);

        // Second match keeps the first id; start while busy must not re-latch.
        do_start("second", 32'd9, MD4_EMPTY);
        start         = 1'b1;
        candidate_id  = 32'd3;
        target_digest = 128'd0;
        tick();
        start = 1'b0;
        check("busy_start_busy", busy, 1'b1);
        check("busy_start_ready", ready, 1'b1);
        send_digest(MD4_EMPTY, -1, 0);
        expect_done("second", 2, 1'b1, 1'b0, MD4_EMPTY, 1'b1, 1'b0);
        check("second_found_id", found_id, 32'd5);

        // Random 50% valid gaps.
        do_start("gaps", 32'd10, GAP_DIG);
        send_digest(GAP_DIG, -1, 50);
        expect_done("gaps", 2, 1'b1, 1'b0, GAP_DIG, 1'b1, 1'b0);

        // Reset after byte 7 discards the partial digest.
        do_start("rst", 32'd11, MD4_EMPTY);
        for (int i = 0; i < 8; i++) begin
            digest_valid = 1'b1;
            digest_byte  = MD4_EMPTY[127 - 8*i -: 8];
            digest_last  = 1'b0;
            tick();
        end
        digest_valid = 1'b0;
        reset        = 1'b1;
        tick();
        check_all_zero("midreset");
        tick();
        reset = 1'b0;
        tick();
        check("midreset_no_done", done, 1'b0);
        tick();
        check("midreset_no_done2", done, 1'b0);
        do_start("fresh", 32'd12, MD4_EMPTY);
        send_digest(MD4_EMPTY, -1, 0);
        expect_done("fresh", 2, 1'b1, 1'b0, MD4_EMPTY, 1'b1, 1'b0);
        check("fresh_found", found, 1'b1);
        check("fresh_found_id", found_id, 32'd12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/md4_digest_checker.md
MD4_DIGEST_CHECKER -- requirements
Module: md4_digest_checker

Interface
REQ-001 Parameter DIGEST_BYTES, default 16, number of digest bytes per hash result.
REQ-002 Parameter ID_W, default 32, width of the candidate identifier.
REQ-003 clk  input  1  single clock; all logic on posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  pulse; arms the checker for one digest.
REQ-006 target_digest  input  128  expected digest; byte 0 in [127:120]; sampled on accepted start.
REQ-007 candidate_id  input  ID_W  identifier of the password under test; sampled on accepted start.
REQ-008 digest_valid  input  1  hasher presents digest_byte this cycle.
REQ-009 digest_byte  input  8  digest byte from the hasher's serial output, byte 0 first.
REQ-010 digest_last  input  1  marks the final digest byte; qualified by digest_valid.
REQ-011 ready  output  1  checker accepts a byte this cycle.
REQ-012 busy  output  1  high from accepted start until done.
REQ-013 done  output  1  one-cycle pulse; the result is valid.
REQ-014 match  output  1  valid with done; collected digest equals target.
REQ-015 error  output  1  valid with done; framing error.
REQ-016 found  output  1  sticky; set on any done with match=1.
REQ-017 found_id  output  ID_W  candidate_id of the first match; held.
REQ-018 digest_out  output  128  last collected digest, same byte order as the target.

Function
REQ-019 FSM states: IDLE, COLLECT, COMPARE, REPORT.
REQ-020 IDLE: start=1 -> latch target/candidate_id, clear byte counter, go to COLLECT next cycle; busy=1 from that edge.
REQ-021 ready=1 only in COLLECT; digest_valid outside COLLECT is ignored.
REQ-022 Byte accepted when digest_valid&&ready; stored at position cnt (cnt=0 -> [127:120]); cnt increments, 5-bit width.
REQ-023 Accepted byte at cnt=DIGEST_BYTES-1 with digest_last=1 -> COMPARE.
REQ-024 digest_last=1 at cnt<DIGEST_BYTES-1, or cnt=DIGEST_BYTES-1 with digest_last=0 -> set error flag, go to REPORT (COMPARE is skipped, and match=0).
REQ-025 COMPARE: one cycle; registers the 128-bit equality result; -> REPORT.
REQ-026 REPORT: done=1 for exactly one cycle with match/error; busy=0 on the same edge; -> IDLE.
REQ-027 Latency: done asserts 2 cycles after the edge accepting the final byte (1 cycle after an error byte).
REQ-028 match and error hold their value until the next done; they are never both 1.
REQ-029 found sets on done&&match; found_id loads only when found was 0 (first match wins); both clear only on reset.
REQ-030 start while busy is ignored; no re-latch.
REQ-031 Gaps (digest_valid=0) in COLLECT are permitted indefinitely; no timeout.
REQ-032 start in the REPORT cycle is ignored; start is accepted from the following IDLE cycle.

Reset
REQ-033 Reset -> IDLE, cnt=0; ready, busy, done, match, error, found = 0; found_id=0, digest_out=0, latched target=0.
REQ-034 Reset mid-COLLECT discards partial digest; no done is produced.

Structure
REQ-035 Shared package md4_pkg: DIGEST_BYTES, FSM state encoding, MD4 initial constants shared with the hasher.
REQ-036 One sub-module, md4_digest_shift (byte-serial 128-bit shift/assemble register with counter); the comparator stays inline.

Verification
REQ-037 Hasher stream of MD4("") = 31d6cfe0d16ae931b73c59d7e0c089c0, target equal -> done one pulse, match=1, found=1, found_id=candidate_id.
REQ-038 Same stream, target with last byte c1 -> match=0, error=0, found unchanged.
REQ-039 digest_last on byte 9 -> done 1 cycle later, error=1, match=0; next start works normally.
REQ-040 Random digest_valid gaps (50%) over 16 bytes -> correct digest_out and match; done 2 cycles after the last byte.
REQ-041 Two matches, ids 5 then 9 -> found_id stays 5; start pulsed while busy has no effect.
REQ-042 Reset asserted after byte 7 -> all outputs 0, no done; fresh digest then checks correctly.
